pc_unit: RTL
============

# pc_unit

Program-counter stage of the single-cycle CPU, directly upstream of the 32-bit `Adder`. It holds the current PC and drives it onto the Adder's `A` operand with a constant increment on `B`. It consumes the Adder's `out` as the sequential next PC and selects among sequential, branch and jump targets. It also handles stalls, buffers a redirect that arrives during a stall, and faults on misaligned targets.

## Interface
- `WIDTH`, 32: PC and target width.
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset.
- `INC`, 4: increment driven on `adder_b`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `adder_out` in WIDTH: result from `Adder`; must equal `adder_a + adder_b`.
- `adder_a` out WIDTH: combinational copy of `pc`.
- `adder_b` out WIDTH: constant `INC`.
- `stall` in 1: hazard hold from downstream.
- `imem_ready` in 1: instruction memory accepts the current `pc`.
- `br_taken` in 1: branch resolved taken this cycle.
- `br_target` in WIDTH: branch destination.
- `jump` in 1: unconditional jump this cycle.
- `jump_target` in WIDTH: jump destination.
- `pc` out WIDTH: current fetch address (registered).
- `pc_valid` out 1: `pc` is a valid fetch request.
- `redirect_pending` out 1: a buffered redirect is waiting.
- `misalign` out 1: sticky fault flag.

## Operation
- **States:**
  - BOOT: entered on reset.
  - RUN.
  - FAULT.
- **Transitions:**
  - BOOT → RUN on the first clock edge after `rst` deasserts.
  - RUN → FAULT on an advance whose selected target has `[1:0] != 0`.
  - FAULT is left only by reset.
- **Advance:** occurs when state = RUN, `imem_ready` = 1 and `stall` = 0. On an advance, `pc` loads the selected next PC.
- **Next-PC priority, highest first:**
  1. `jump` → `jump_target`
  2. `br_taken` → `br_target`
  3. pending buffer → buffered target
  4. otherwise `adder_out`
- A live redirect in the advancing cycle overrides the pending buffer, and the buffer clears.
- **Hold:** in RUN without an advance, `pc` is unchanged and `pc_valid` stays 1.
- **Pending buffer:** one entry (valid bit plus target).
  - Loads when `jump` or `br_taken` is asserted in a non-advancing RUN cycle.
  - Jump beats branch within the same cycle.
  - A later redirect overwrites an earlier one.
  - Clears on the advance that consumes it.
- `redirect_pending` = buffer valid.
- **Alignment:** checked only on the target actually selected. Sequential targets are checked too; they cannot fault when `INC` = 4 and the PC is aligned.
- **On fault:**
  - `pc` keeps its last value.
  - `misalign` = 1 and `pc_valid` = 0.
  - The pending buffer clears.
  - All inputs are ignored.
- **Arithmetic:** the wrap is performed by the Adder. `pc` = 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- **Inputs ignored:** redirect and stall inputs are ignored in BOOT and FAULT.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`
  - `pc_valid` = 0
  - `redirect_pending` = 0
  - `misalign` = 0
  - state = BOOT
- `adder_a` and `adder_b` follow reset values combinationally.
- **Reset assertion** clears all state immediately and asynchronously, including mid-stall and with the buffer full.
- **After reset release:**
  - `pc_valid` rises after 1 edge.
  - The first advance is possible at the 2nd edge.
- **Latency:**
  - Redirect in cycle N with an advance → `pc` = target after edge N.
  - A redirect during a stall is applied at the first advancing edge.
- `stall` and `imem_ready` = 0 are equivalent holds; both must be clear to advance.
- No combinational path from any input to `pc` or `pc_valid`. `adder_a` depends only on registered `pc`.

## Test plan
- **Reset and sequential:** reset low for 3 cycles, release, `imem_ready` = 1 → `pc_valid` rises after 1 edge; `pc` = 0, 4, 8, 12 on successive edges; `adder_a` tracks `pc`.
- **Jump beats branch:** at `pc` = 8, `jump` = 1 with `jump_target` = 0x100, `br_taken` = 1 with `br_target` = 0x200 → `pc` = 0x100 next; then 0x104.
- **Redirect during stall:** at `pc` = 0x10, `stall` = 1 for 3 cycles; `br_taken` pulses with 0x40 in cycle 1 → `redirect_pending` = 1, `pc` held at 0x10; release → `pc` = 0x40, pending clears.
- **Live redirect overrides buffer:** pending = 0x40; advance cycle with `jump_target` = 0x80 → `pc` = 0x80, pending = 0.
- **Misalign fault:** `br_target` = 0x42 taken → `misalign` = 1, `pc_valid` = 0, `pc` unchanged; further jumps are ignored until reset.
- **Wrap and async reset:** `RESET_PC` = 32'hFFFF_FFF8 → advances to FFFF_FFFC, then 0000_0000. Assert `rst` mid-stall with the buffer full → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter: selects jump > branch > buffered redirect > sequential adder result; one-cycle update.
// Holds while stall or !imem_ready; redirects seen during a hold are buffered (one entry, latest wins).
module pc_unit #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter int                 INC      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adder_out,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             redirect_pending,
  output logic             misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             pend_vld, pend_vld_n;
  logic [WIDTH-1:0] pend_target, pend_target_n;

  logic             advance;
  logic             live;
  logic [WIDTH-1:0] live_target;
  logic [WIDTH-1:0] sel_target;

  assign advance     = (state == RUN) && imem_ready && !stall;
  assign live        = jump || br_taken;
  assign live_target = jump ? jump_target : br_target;
  assign sel_target  = live ? live_target : (pend_vld ? pend_target : adder_out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_vld    <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_vld    <= pend_vld_n;
      pend_target <= pend_target_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_vld_n    = pend_vld;
    pend_target_n = pend_target;
    case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (advance) begin
          pend_vld_n = 1'b0;
          // a misaligned target freezes pc at its last good value
          if (sel_target[1:0] != 2'b00) begin
            state_n = FAULT;
          end else begin
            pc_n = sel_target;
          end
        end else if (live) begin
          pend_vld_n    = 1'b1;
          pend_target_n = live_target;
        end
      end
      FAULT: begin
        pend_vld_n = 1'b0;
      end
      default: begin
        state_n    = BOOT;
        pend_vld_n = 1'b0;
      end
    endcase
  end

  // all status outputs come straight from registers, so no input reaches them combinationally
  assign pc_valid         = (state == RUN);
  assign misalign         = (state == FAULT);
  assign redirect_pending = pend_vld;
  assign adder_a          = pc;
  assign adder_b          = WIDTH'(INC);

endmodule
